// File: rtl/phase_seq_mod6.sv
// Two-state phase sequencer: steps a 3-bit code through 0..LAST, up or down,
// at a programmable prescaled rate, with single-step, load and wrap pulse.
module phase_seq_mod6 #(
    parameter int DIV_W = 8,
    parameter int LAST  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             step,
    input  logic             load,
    input  logic [2:0]       load_val,
    input  logic [DIV_W-1:0] div,
    output logic [2:0]       a,
    output logic             busy,
    output logic             wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] LAST_C = 3'(LAST);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_a;
    logic             r_busy;
    logic             r_wrap;

    logic             w_tick;
    logic             w_step_adv;
    logic             w_adv;
    logic             w_at_end;
    logic [2:0]       w_a_adv;
    logic [2:0]       w_a_load;

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: default assignment first keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start && !stop) w_state_nxt = RUN;
            RUN:     if (stop)           w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tick     = 1'b0;
        w_step_adv = 1'b0;
        case (r_state)
            IDLE:    w_step_adv = step && !start;
            RUN:     w_tick     = (r_cnt >= div);
            default: ;
        endcase
    end

    // Load wins over both tick and step; the wrap pulse follows the real advance only.
    assign w_adv    = !load && (w_tick || w_step_adv);
    assign w_at_end = dir ? (r_a == 3'd0) : (r_a == LAST_C);
    assign w_a_adv  = dir ? ((r_a == 3'd0) ? LAST_C : r_a - 3'd1)
                          : ((r_a == LAST_C) ? 3'd0 : r_a + 3'd1);
    assign w_a_load = (load_val > LAST_C) ? LAST_C : load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= 3'd0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == RUN);
            r_wrap <= w_adv && w_at_end;
            if (load)       r_a <= w_a_load;
            else if (w_adv) r_a <= w_a_adv;
            // Prescaler runs only between two RUN cycles; anything else restarts it.
            if (load || w_tick || (r_state != RUN) || (w_state_nxt != RUN))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign a    = r_a;
    assign busy = r_busy;
    assign wrap = r_wrap;

endmodule

// File: doc/phase_seq_mod6.md
PHASE_SEQ_MOD6 -- requirements
Module: phase_seq_mod6

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DIV_W, default 8, SHALL set the prescaler width.
REQ-003 Parameter LAST, default 5, SHALL set the highest code value; legal range is 1..7.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: request IDLE->RUN.
REQ-007 Port stop, input, 1 bit: request RUN->IDLE.
REQ-008 Port dir, input, 1 bit: 0 = count up, 1 = count down.
REQ-009 Port step, input, 1 bit: single advance, honoured in IDLE only.
REQ-010 Port load, input, 1 bit: synchronous code load.
REQ-011 Port load_val, input, 3 bits: value to load.
REQ-012 Port div, input, DIV_W bits: advance period in RUN is div+1 clocks.
REQ-013 Port a, output, 3 bits: registered code that drives the 3-to-6 decoder input.
REQ-014 Port busy, output, 1 bit: registered, high while in RUN.
REQ-015 Port wrap, output, 1 bit: one-cycle pulse on code wrap-around.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-017 In IDLE, start=1 with stop=0 SHALL move the FSM to RUN at the next edge; in RUN, stop=1 SHALL move it to IDLE at the next edge.
REQ-018 When start and stop are both high, stop SHALL dominate: the FSM goes to or stays in IDLE.
REQ-019 Prescaler cnt (DIV_W bits) SHALL be 0 in IDLE and 0 in the first RUN cycle; it increments each RUN cycle.
REQ-020 When cnt >= div in RUN, a tick SHALL occur: cnt <= 0 and code a advances one position at that edge.
REQ-021 div SHALL be sampled live each cycle, and lowering div below the current cnt SHALL cause a tick on the next edge.
REQ-022 In up mode, a SHALL advance as a == LAST -> 0, otherwise a+1.
REQ-023 In down mode, a SHALL advance as a == 0 -> LAST, otherwise a-1.
REQ-024 a SHALL never leave the range 0..LAST.
REQ-025 With div=D, after the edge that enters RUN, a SHALL change at edges D+1, 2(D+1), ...; div=0 gives one advance per clock.
REQ-026 wrap SHALL be high for exactly the one cycle following the edge at which a goes LAST->0 (up) or 0->LAST (down), and low otherwise.
REQ-027 step=1 in IDLE with start=0 SHALL advance a once in direction dir, and SHALL pulse wrap if that advance wraps.
REQ-028 step SHALL be ignored in RUN, and ignored when start=1.
REQ-029 load SHALL have the highest priority: a <= load_val, clamped to LAST if load_val > LAST.
REQ-030 A load SHALL force cnt <= 0, SHALL produce no wrap, SHALL suppress any coincident tick or step, and SHALL not change the FSM state.
REQ-031 dir changes SHALL take effect at the next advance, with no other side effect.
REQ-032 busy SHALL equal (state == RUN), registered.

Reset
REQ-033 rst=1 SHALL, immediately and without waiting for clk, force state=IDLE, a=0, cnt=0, busy=0 and wrap=0.
REQ-034 Reset asserted mid-RUN SHALL abort the sequence, and after release the block SHALL stay in IDLE until start.
REQ-035 Reset release SHALL be sampled on clk, and no advance SHALL occur on the release edge unless start, step or load is asserted.

Verification
REQ-036 Scenario: reset; dir=0, div=0, pulse start. Required response: a = 0,1,2,3,4,5,0,1 on consecutive clocks, busy=1, and wrap high only in the cycle a first shows 0 after 5.
REQ-037 Scenario: div=3, up, start, stop asserted the cycle after a becomes 2. Required response: a changes every 4 clocks, a holds 2, and busy drops at the next edge.
REQ-038 Scenario: a=0, dir=1, div=0, RUN. Required response: a = 5 with wrap=1, then 4, 3; a later dir=0 reverses at the next advance.
REQ-039 Scenario: load with load_val=7. Required response: a=5.
REQ-040 Scenario: in RUN with div=3, load with load_val=3 on a tick cycle. Required response: a=3, no wrap, and the next advance 4 clocks later.
REQ-041 Scenario: IDLE, a=5, dir=0, step. Required response: a=0 and wrap=1.
REQ-042 Scenario: step in RUN. Required response: no extra advance.
REQ-043 Scenario: start and stop together in IDLE. Required response: busy stays 0.
REQ-044 Scenario: RUN at a=4, assert rst between edges. Required response: a=0 and busy=0 before the next clk edge.
REQ-045 Scenario: release rst. Required response: a remains 0 and IDLE is held.
